// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder
// Description : Multi-cycle add/subtract, CHUNK bits per clock, LSB chunk first.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder #(
   parameter int WIDTH = 8,
   parameter int CHUNK = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             ovf
);

   localparam int c_steps = WIDTH / CHUNK;
   localparam int c_cnt_w = (c_steps > 1) ? $clog2(c_steps) : 1;
   localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_steps - 1);
   localparam logic [c_cnt_w-1:0] c_one  = c_cnt_w'(1);

   generate
      if ((WIDTH < 2) || (CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
         $error("serial_adder: CHUNK must divide WIDTH and WIDTH must be >= 2");
      end
   endgenerate

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t              r_state;
   logic [WIDTH-1:0]    r_a;
   logic [WIDTH-1:0]    r_b;
   logic                r_c;
   logic [WIDTH-1:0]    r_res;
   logic [c_cnt_w-1:0]  r_cnt;

   logic [31:0]         w_base;
   logic [CHUNK:0]      w_step;
   logic [WIDTH-1:0]    w_res;

   // Current chunk sum, and the result register with that chunk merged in
   always_comb begin
      w_base = 32'(r_cnt) * 32'(CHUNK);
      w_step = {1'b0, r_a[w_base +: CHUNK]} + {1'b0, r_b[w_base +: CHUNK]}
             + {{CHUNK{1'b0}}, r_c};
      w_res  = r_res;
      w_res[w_base +: CHUNK] = w_step[CHUNK-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_c     <= 1'b0;
         r_res   <= '0;
         r_cnt   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         sum     <= '0;
         carry   <= 1'b0;
         ovf     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  // Subtract is folded into add: a + ~b + ~cin
                  r_a     <= a;
                  r_b     <= sub ? ~b : b;
                  r_c     <= sub ? ~cin : cin;
                  r_res   <= '0;
                  r_cnt   <= '0;
                  busy    <= 1'b1;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               r_res <= w_res;
               r_c   <= w_step[CHUNK];
               r_cnt <= r_cnt + c_one;
               if (r_cnt == c_last) begin
                  r_cnt   <= '0;
                  r_state <= S_IDLE;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  sum     <= w_res;
                  carry   <= w_step[CHUNK];
                  ovf     <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                             (w_res[WIDTH-1] != r_a[WIDTH-1]);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_adder
// Description : Self-checking bench for serial_adder over several WIDTH/CHUNK builds.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [4:0] st = '0;
   logic       sub = 1'b0;
   logic       cin = 1'b0;
   logic [7:0] a8 = '0;
   logic [7:0] b8 = '0;

   logic       busy_v [5];
   logic       done_v [5];
   logic       carry_v[5];
   logic       ovf_v  [5];
   logic [7:0] sum_v  [5];
   logic [3:0] s4     [5];

   int checks = 0;
   int errors = 0;
   int prev [5];

   always #5 clk = ~clk;

   // Instances: 0 = 8/1, 1 = 8/4, 2 = 4/1, 3 = 4/2, 4 = 4/4
   serial_adder #(.WIDTH(8), .CHUNK(1)) u_8c1 (
      .clk(clk), .rst_n(rst_n), .start(st[0]), .sub(sub), .a(a8), .b(b8), .cin(cin),
      .busy(busy_v[0]), .done(done_v[0]), .sum(sum_v[0]), .carry(carry_v[0]), .ovf(ovf_v[0]));
   serial_adder #(.WIDTH(8), .CHUNK(4)) u_8c4 (
      .clk(clk), .rst_n(rst_n), .start(st[1]), .sub(sub), .a(a8), .b(b8), .cin(cin),
      .busy(busy_v[1]), .done(done_v[1]), .sum(sum_v[1]), .carry(carry_v[1]), .ovf(ovf_v[1]));
   serial_adder #(.WIDTH(4), .CHUNK(1)) u_4c1 (
      .clk(clk), .rst_n(rst_n), .start(st[2]), .sub(sub), .a(a8[3:0]), .b(b8[3:0]), .cin(cin),
      .busy(busy_v[2]), .done(done_v[2]), .sum(s4[2]), .carry(carry_v[2]), .ovf(ovf_v[2]));
   serial_adder #(.WIDTH(4), .CHUNK(2)) u_4c2 (
      .clk(clk), .rst_n(rst_n), .start(st[3]), .sub(sub), .a(a8[3:0]), .b(b8[3:0]), .cin(cin),
      .busy(busy_v[3]), .done(done_v[3]), .sum(s4[3]), .carry(carry_v[3]), .ovf(ovf_v[3]));
   serial_adder #(.WIDTH(4), .CHUNK(4)) u_4c4 (
      .clk(clk), .rst_n(rst_n), .start(st[4]), .sub(sub), .a(a8[3:0]), .b(b8[3:0]), .cin(cin),
      .busy(busy_v[4]), .done(done_v[4]), .sum(s4[4]), .carry(carry_v[4]), .ovf(ovf_v[4]));

   assign sum_v[2] = {4'h0, s4[2]};
   assign sum_v[3] = {4'h0, s4[3]};
   assign sum_v[4] = {4'h0, s4[4]};
   assign s4[0] = 4'h0;
   assign s4[1] = 4'h0;

   function automatic int width_of(int idx);
      return (idx < 2) ? 8 : 4;
   endfunction

   function automatic int steps_of(int idx);
      case (idx)
         0:       return 8;
         1:       return 2;
         2:       return 4;
         3:       return 2;
         default: return 1;
      endcase
   endfunction

   // Arithmetic reference: unsigned result/carry and signed range test
   task automatic model(input int w, input int av, input int bv, input int ci, input int sb,
                        output int es, output int ec, output int eo);
      int full, sa, sbb, r, half;
      half = 1 << (w - 1);
      if (sb == 0) begin
         full = av + bv + ci;
         ec   = (full >= (1 << w)) ? 1 : 0;
      end else begin
         full = av - bv - ci;
         ec   = (full >= 0) ? 1 : 0;
      end
      es  = full & ((1 << w) - 1);
      sa  = (av >= half) ? av - (1 << w) : av;
      sbb = (bv >= half) ? bv - (1 << w) : bv;
      r   = (sb == 0) ? sa + sbb + ci : sa - sbb - ci;
      eo  = ((r < -half) || (r > half - 1)) ? 1 : 0;
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic run_op(input int idx, input int av, input int bv, input int ci, input int sb,
                         input int es, input int ec, input int eo);
      int lat;
      @(negedge clk);
      chk("done_idle_low", int'(done_v[idx]), 0);
      a8 = 8'(av); b8 = 8'(bv); cin = ci[0]; sub = sb[0]; st[idx] = 1'b1;
      @(negedge clk);
      st[idx] = 1'b0;
      chk("busy_after_start", int'(busy_v[idx]), 1);
      chk("sum_held_in_run", int'(sum_v[idx]), prev[idx]);
      lat = 0;
      while (!done_v[idx] && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      chk("latency", lat, steps_of(idx));
      chk("busy_at_done", int'(busy_v[idx]), 0);
      chk("sum", int'(sum_v[idx]), es);
      chk("carry", int'(carry_v[idx]), ec);
      chk("ovf", int'(ovf_v[idx]), eo);
      prev[idx] = es;
   endtask

   typedef struct {
      int idx; int a; int b; int cin; int sub; int es; int ec; int eo;
   } vec_t;

   vec_t tbl[5];

   initial begin
      int es, ec, eo, lat, dones;
      tbl[0] = '{0, 'hFF, 'h01, 0, 0, 'h00, 1, 0};
      tbl[1] = '{0, 'h7F, 'h01, 0, 0, 'h80, 0, 1};
      tbl[2] = '{0, 'h05, 'h07, 0, 1, 'hFE, 0, 0};
      tbl[3] = '{1, 'hA5, 'h5A, 1, 0, 'h00, 1, 0};
      tbl[4] = '{2, 'h7,  'h1,  0, 0, 'h8,  0, 1};
      for (int i = 0; i < 5; i++) prev[i] = 0;

      repeat (2) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         chk("rst_busy", int'(busy_v[i]), 0);
         chk("rst_done", int'(done_v[i]), 0);
         chk("rst_sum", int'(sum_v[i]), 0);
         chk("rst_carry", int'(carry_v[i]), 0);
         chk("rst_ovf", int'(ovf_v[i]), 0);
      end
      rst_n = 1'b1;

      for (int i = 0; i < 5; i++)
         run_op(tbl[i].idx, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub,
                tbl[i].es, tbl[i].ec, tbl[i].eo);

      // Start pulsed 3 cycles into a run must be ignored
      @(negedge clk);
      a8 = 8'h10; b8 = 8'h20; cin = 1'b0; sub = 1'b0; st[0] = 1'b1;
      @(negedge clk);
      st[0] = 1'b0;
      repeat (2) @(negedge clk);
      a8 = 8'h33; b8 = 8'h44; cin = 1'b1; sub = 1'b1; st[0] = 1'b1;
      @(negedge clk);
      st[0] = 1'b0;
      dones = 0;
      repeat (12) begin
         @(negedge clk);
         if (done_v[0]) dones++;
      end
      chk("ignored_start_dones", dones, 1);
      chk("ignored_start_sum", int'(sum_v[0]), 'h30);
      chk("ignored_start_busy", int'(busy_v[0]), 0);
      prev[0] = 'h30;

      // Start during the done cycle is accepted
      a8 = 8'h0F; b8 = 8'h01; cin = 1'b0; sub = 1'b0; st[0] = 1'b1;
      @(negedge clk);
      st[0] = 1'b0;
      lat = 0;
      while (!done_v[0] && lat < 40) begin @(negedge clk); lat++; end
      chk("b2b_first_sum", int'(sum_v[0]), 'h10);
      a8 = 8'h20; b8 = 8'h02; st[0] = 1'b1;
      @(negedge clk);
      st[0] = 1'b0;
      chk("b2b_done_deassert", int'(done_v[0]), 0);
      chk("b2b_busy", int'(busy_v[0]), 1);
      lat = 0;
      while (!done_v[0] && lat < 40) begin @(negedge clk); lat++; end
      chk("b2b_latency", lat, 8);
      chk("b2b_second_sum", int'(sum_v[0]), 'h22);
      prev[0] = 'h22;

      // Asynchronous reset mid-run
      @(negedge clk);
      a8 = 8'h01; b8 = 8'h01; st[0] = 1'b1;
      @(negedge clk);
      st[0] = 1'b0;
      repeat (4) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_busy", int'(busy_v[0]), 0);
      chk("abort_done", int'(done_v[0]), 0);
      chk("abort_sum", int'(sum_v[0]), 0);
      chk("abort_carry", int'(carry_v[0]), 0);
      chk("abort_ovf", int'(ovf_v[0]), 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) prev[i] = 0;
      dones = 0;
      repeat (12) begin
         @(negedge clk);
         if (done_v[0]) dones++;
      end
      chk("no_stale_done", dones, 0);
      model(8, 'h3C, 'h0F, 1, 1, es, ec, eo);
      run_op(0, 'h3C, 'h0F, 1, 1, es, ec, eo);

      // Exhaustive WIDTH=4 sweep on every chunking
      for (int d = 2; d < 5; d++)
         for (int v = 0; v < 1024; v++) begin
            model(4, v & 15, (v >> 4) & 15, (v >> 8) & 1, (v >> 9) & 1, es, ec, eo);
            run_op(d, v & 15, (v >> 4) & 15, (v >> 8) & 1, (v >> 9) & 1, es, ec, eo);
         end

      // Random 8-bit operations
      for (int k = 0; k < 200; k++) begin
         int d, av, bv, ci, sb;
         d  = int'($urandom_range(0, 1));
         av = int'($urandom_range(0, 255));
         bv = int'($urandom_range(0, 255));
         ci = int'($urandom_range(0, 1));
         sb = int'($urandom_range(0, 1));
         model(width_of(d), av, bv, ci, sb, es, ec, eo);
         run_op(d, av, bv, ci, sb, es, ec, eo);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/serial_adder.md
# serial_adder

Parametrised multi-cycle adder/subtractor, successor to the single-bit half adder. It adds or subtracts two WIDTH-bit operands CHUNK bits per clock, least-significant chunk first, carrying between chunks in a register. A start/busy/done handshake lets the block sit on a shared datapath where area matters more than latency.

## Interface
- WIDTH, 8: operand and result width in bits; WIDTH ≥ 2.
- CHUNK, 1: bits processed per cycle; must divide WIDTH; CHUNK = WIDTH gives a one-step adder.
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- start  input  1  request; sampled on a rising edge while busy = 0.
- sub  input  1  0 = add, 1 = subtract; captured with start.
- a  input  WIDTH  operand A; captured with start.
- b  input  WIDTH  operand B; captured with start.
- cin  input  1  carry-in for add, or borrow-in for subtract; captured with start.
- busy  output  1  high while a computation is in progress.
- done  output  1  one-cycle pulse: sum, carry and ovf have just been updated.
- sum  output  WIDTH  result, held until the next completion.
- carry  output  1  unsigned carry-out; for subtract, 1 = no borrow.
- ovf  output  1  two's-complement signed overflow.

## Operation
- N = WIDTH / CHUNK steps per operation.
- Effective operand and carry:
  - b_eff = sub ? ~b : b
  - c0 = sub ? ~cin : cin
- Result: sum = a − b − cin mod 2^WIDTH when sub = 1, otherwise a + b + cin mod 2^WIDTH.
- ovf = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]).
- State machine: IDLE → RUN → IDLE.
  - IDLE: busy = 0. start = 1 at an edge captures a, b_eff and c0 into internal registers, clears the step counter and enters RUN.
  - RUN: busy = 1. Each edge adds chunk i of a and b_eff plus the carry register, writes CHUNK bits into the internal result register, updates the carry register and increments i.
  - After step N−1, return to IDLE, copy the internal result to sum/carry/ovf and assert done for one cycle.
- start while busy = 1 is ignored; operand changes during RUN have no effect.
- sum/carry/ovf change only at completion. During RUN they hold the previous result.
- Asserting rst_n low at any time, including mid-RUN, aborts the operation immediately:
  - state returns to IDLE;
  - all internal registers clear;
  - no done pulse is generated.
- Illegal parameters (CHUNK not dividing WIDTH) must fail elaboration.

## Timing
- Reset values: busy = 0, done = 0, sum = 0, carry = 0, ovf = 0; state IDLE; step counter 0.
- start sampled high at edge k:
  - busy = 1 from edge k.
  - Steps occur at edges k+1 … k+N.
  - At edge k+N: busy = 0, done = 1, results valid.
  - done returns to 0 at edge k+N+1.
- Latency: start edge to done assertion is N cycles. Throughput is one operation per N+1 cycles, counting from each start edge.
- Back-to-back: start may be high during the done cycle. It is accepted at edge k+N+1, and done still deasserts at that edge.
- start held high continuously re-triggers at every IDLE edge. No edge detection is performed.
- The carry register carries between chunks only. Its final value after step N−1 becomes carry; it does not leak into the next operation, which is reseeded from c0.

## Test plan
- WIDTH=8, CHUNK=1, start with a=0xFF, b=0x01, cin=0, sub=0 → done exactly 8 cycles after the start edge; sum=0x00, carry=1, ovf=0; busy high for 8 cycles.
- WIDTH=8, CHUNK=1, a=0x7F, b=0x01, cin=0, sub=0 → sum=0x80, carry=0, ovf=1. Then a=0x05, b=0x07, cin=0, sub=1 → sum=0xFE, carry=0 (borrow), ovf=0.
- WIDTH=8, CHUNK=4, a=0xA5, b=0x5A, cin=1, sub=0 → done 2 cycles after start; sum=0x00, carry=1, ovf=0.
- Pulse start again 3 cycles into a run with different operands → second request ignored; result matches the first operands only; exactly one done pulse. A start during the done cycle is accepted, with the next done N cycles later.
- Drop rst_n low mid-RUN (step 4 of 8) → busy, done, sum, carry and ovf read 0 asynchronously. After release, no stale done appears and a fresh operation completes correctly.
- Sweep all (a, b, cin, sub) for WIDTH=4 with CHUNK ∈ {1, 2, 4} against a behavioural reference → every sum, carry and ovf matches; done latency equals WIDTH/CHUNK.
